// File: rtl/subinv_sched_pkg.sv
// rtl/subinv_sched_pkg.sv - shared state type, tag width and round-robin pick for subinvmult_sched
package subinv_sched_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } sched_state_e;

  // Tags are sized for the largest supported requester count so one width serves every build.
  localparam int MAX_NREQ = 8;
  localparam int TAG_W    = $clog2(MAX_NREQ);

  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] elig,
    input logic [TAG_W-1:0]    ptr,
    input int                  n
  );
    logic [MAX_NREQ-1:0] pick;
    logic                found;
    int                  idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && !found && elig[idx[TAG_W-1:0]]) begin
        pick[idx[TAG_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/subinv_tag_pipe.sv
// rtl/subinv_tag_pipe.sv - valid+tag delay line that shadows the datapath operand and pipeline stages
module subinv_tag_pipe
  import subinv_sched_pkg::*;
#(
  parameter int DEPTH = 9
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             any_valid_o
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q  <= {valid_q[DEPTH-2:0], valid_i};
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign tag_o       = tag_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/subinvmult_sched.sv
// rtl/subinvmult_sched.sv - round-robin scheduler sharing one SubInvMult pipeline among requesters
// Define SUBINV_SCHED_PRIO0_EN to give requester 0 strict priority over the rotation.
module subinvmult_sched
  import subinv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int NREQ       = 4,
  parameter int LATENCY    = 8,
  parameter int MAX_OUT    = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_a,
  input  logic [NREQ*DATA_WIDTH-1:0] req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]      dp_a,
  output logic [DATA_WIDTH-1:0]      dp_b,
  input  logic [DATA_WIDTH-1:0]      dp_result,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  input  logic                       drain_req,
  output logic                       busy,
  output logic                       drained
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  sched_state_e          state_q, state_d;
  logic [TAG_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      out_q [NREQ];
  logic [CNT_W-1:0]      out_d [NREQ];
  logic [DATA_WIDTH-1:0] dp_a_q, dp_b_q, rsp_data_q;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]       elig, grant;
  logic [MAX_NREQ-1:0]   elig_ext, pick;
  logic [TAG_W-1:0]      grant_tag;
  logic                  grant_any, prio_hit, can_grant;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  logic                  pipe_valid, pipe_busy;
  logic [TAG_W-1:0]      pipe_tag;

  // A response retiring this cycle frees its slot, so a full requester can be re-granted at once.
  always_comb begin
    elig     = '0;
    elig_ext = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i]     = req_valid[i] &&
                    ((out_q[i] < CNT_W'(MAX_OUT)) || rsp_valid_q[i]);
      elig_ext[i] = elig[i];
    end
    can_grant = (state_q == RUN) && !drain_req && !reset;
    pick      = rr_pick(elig_ext, ptr_q, NREQ);
    prio_hit  = 1'b0;
`ifdef SUBINV_SCHED_PRIO0_EN
    if (elig[0]) begin
      pick     = '0;
      pick[0]  = 1'b1;
      prio_hit = 1'b1;
    end
`endif
    grant = '0;
    if (can_grant) begin
      for (int i = 0; i < NREQ; i++) begin
        grant[i] = pick[i];
      end
    end
    grant_any = can_grant && (|pick);
    grant_tag = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_tag = TAG_W'(i);
        sel_a     = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b     = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any && !prio_hit) begin
      ptr_d = (grant_tag == TAG_W'(NREQ - 1)) ? '0 : grant_tag + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      out_d[i] = out_q[i];
      if (grant[i] && !rsp_valid_q[i]) begin
        out_d[i] = out_q[i] + 1'b1;
      end else if (!grant[i] && rsp_valid_q[i]) begin
        out_d[i] = out_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = pipe_valid && (pipe_tag == TAG_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req)  state_d = DRAIN;
      DRAIN:   if (!busy)      state_d = HALT;
      HALT:    if (!drain_req) state_d = RUN;
      default:                 state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      if (grant_any) begin
        dp_a_q <= sel_a;
        dp_b_q <= sel_b;
      end
      if (pipe_valid) begin
        rsp_data_q <= dp_result;
      end
      for (int i = 0; i < NREQ; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  // One extra stage covers the dp_a/dp_b register ahead of the datapath.
  subinv_tag_pipe #(
    .DEPTH(LATENCY + 1)
  ) u_tag_pipe (
    .clk_i      (clk),
    .reset_i    (reset),
    .valid_i    (grant_any),
    .tag_i      (grant_tag),
    .valid_o    (pipe_valid),
    .tag_o      (pipe_tag),
    .any_valid_o(pipe_busy)
  );

  assign req_ready = grant;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = pipe_busy | (|rsp_valid_q);
  assign drained   = (state_q == HALT);

endmodule

// File: tb/tb_subinvmult_sched.sv
// tb/tb_subinvmult_sched.sv - randomized scoreboard bench for subinvmult_sched with a stub datapath
module tb_subinvmult_sched;

  localparam int DW   = 18;
  localparam int N    = 4;
  localparam int LAT  = 8;
  localparam int MAXO = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   dp_a, dp_b, dp_result, rsp_data;
  logic            drain_req, busy, drained;

  subinvmult_sched #(
    .DATA_WIDTH(DW), .NREQ(N), .LATENCY(LAT), .MAX_OUT(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .drain_req(drain_req),
    .busy(busy), .drained(drained)
  );

  always #5 clk = ~clk;

  // Stub datapath: returns a-b after LAT cycles, never reset, like the real pipeline.
  logic [DW-1:0] stub_q [LAT];
  always @(posedge clk) begin
    stub_q[0] <= dp_a - dp_b;
    for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
  end
  assign dp_result = stub_q[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            model_out [N];
  int            model_ptr = 0;
  int            mon_idx;
  bit            mon_hit;
  bit            arb_chk = 1'b0;
  int            rsp_count = 0;
  logic [N-1:0]  mon_exp;
  logic [DW-1:0] mon_d;

  // Monitor: retire responses in issue order, predict the grant, then record this cycle's transfers.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      for (int i = 0; i < N; i++) model_out[i] = 0;
      model_ptr = 0;
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("rsp_missing", cyc, sb[0].due);
        model_out[sb[0].tag]--;
        void'(sb.pop_front());
      end
      if (rsp_valid != '0) begin
        rsp_count++;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_tag", rsp_valid, 1 << mon_e.tag);
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_latency", cyc, mon_e.due);
          model_out[mon_e.tag]--;
        end
      end
      mon_exp = '0;
      mon_hit = 1'b0;
`ifdef SUBINV_SCHED_PRIO0_EN
      if (req_valid[0] && model_out[0] < MAXO) begin
        mon_exp[0] = 1'b1;
        mon_hit    = 1'b1;
      end
`endif
      for (int k = 0; k < N && !mon_hit; k++) begin
        mon_idx = (model_ptr + k) % N;
        if (req_valid[mon_idx] && model_out[mon_idx] < MAXO) begin
          mon_exp[mon_idx] = 1'b1;
          mon_hit          = 1'b1;
        end
      end
      if (arb_chk) chk("grant", req_ready, mon_exp);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_d = req_a[i*DW +: DW] - req_b[i*DW +: DW];
          sb.push_back('{tag: i, data: mon_d, due: cyc + LAT + 2});
          model_out[i]++;
`ifdef SUBINV_SCHED_PRIO0_EN
          if (i != 0) model_ptr = (i + 1) % N;
`else
          model_ptr = (i + 1) % N;
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = DW'($urandom);
      req_b[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_wait", int'(n < 100), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g_count, base;
    req_valid = '0; req_a = '0; req_b = '0; drain_req = 1'b0;
    repeat (2) @(posedge clk);
    req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_dp_b", dp_b, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drained", drained, 0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0; arb_chk = 1'b1;
    step();

    // Single request: 100-30 returns to requester 0 ten cycles after grant.
    req_valid = 4'b0001;
    req_a[0 +: DW] = DW'(100);
    req_b[0 +: DW] = DW'(30);
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    n = 1;
    @(negedge clk);
    while (rsp_valid == '0 && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("single_latency", n, LAT + 2);
    chk("single_data", rsp_data, 70);
    chk("single_busy_at_rsp", busy, 1);
    @(negedge clk);
    chk("single_busy_fall", busy, 0);
    step();

    // Continuous load then random valid patterns.
    for (int c = 0; c < 40; c++) begin
      rand_ops();
      req_valid = '1;
      step();
    end
    for (int c = 0; c < 200; c++) begin
      rand_ops();
      req_valid = N'($urandom);
      step();
    end
    req_valid = '0;
    wait_idle();

    // Outstanding limit on requester 2 alone.
    req_valid = 4'b0100;
    g_count = 0;
    for (int c = 0; c < 25; c++) begin
      rand_ops();
      @(negedge clk);
      if (c == 10) begin
        chk("limit_count", g_count, MAXO);
        chk("limit_regrant_with_rsp", {req_ready[2], rsp_valid[2]}, 2'b11);
      end
      g_count += int'(req_ready[2]);
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_idle();

    // Drain with five in flight.
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      req_valid = '1;
      step();
    end
    drain_req = 1'b1;
    arb_chk   = 1'b0;
    base      = rsp_count;
    @(negedge clk);
    chk("drain_no_grant_first", req_ready, 0);
    @(posedge clk); #1;
    drain_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      chk("drain_no_grant", req_ready, 0);
      n++;
      @(negedge clk);
    end
    chk("drain_bounded", int'(n < 50), 1);
    chk("drain_not_yet_halt", drained, 0);
    @(negedge clk);
    chk("drain_halted", drained, 1);
    chk("drain_halt_no_grant", req_ready, 0);
    chk("drain_rsp_count", rsp_count - base, 5);
    #1 arb_chk = 1'b1;
    @(negedge clk);
    chk("drain_resume_drained", drained, 0);
    chk("drain_resume_grant", int'(req_ready != '0), 1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reset with six in flight discards them.
    for (int c = 0; c < 6; c++) begin
      rand_ops();
      req_valid = '1;
      step();
    end
    reset = 1'b1; arb_chk = 1'b0; req_valid = '0;
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    arb_chk   = 1'b1;
    @(negedge clk);
    chk("post_rst_grant_req0", req_ready, 4'b0001);
    @(posedge clk); #1;

    for (int c = 0; c < 150; c++) begin
      rand_ops();
      req_valid = N'($urandom);
      step();
    end
    req_valid = '0;
    wait_idle();
    step();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
